// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the peripheral-bus interrupt controller.
// BASE_ADDR is also consumed by the system bridge address decode.
package int_ctrl_pkg;
  localparam int          NSRC         = 6;
  localparam logic [31:0] BASE_ADDR    = 32'h0000_7f20;
  localparam int          CTRL_GEN_BIT = 8;

  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_PEND = 2'd2;
  localparam logic [1:0] OFF_ID   = 2'd3;

  typedef logic [NSRC-1:0] src_vec_t;

  typedef struct packed {
    logic     gen;
    src_vec_t mode;
  } ctrl_t;

  // Lowest set index; 0 when the vector is empty.
  function automatic logic [2:0] lowest_idx(input src_vec_t v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NSRC-1; i >= 0; i--)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/int_ctrl_if.sv
// Processor peripheral bus as seen by one memory-mapped slave.
interface int_ctrl_if;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic [31:0] PrRD;
  logic        hit;

  modport master (output PrAddr, PrWD, PrWE, input PrRD, hit);
  modport slave  (input PrAddr, PrWD, PrWE, output PrRD, hit);
endinterface

// File: rtl/int_src_cell.sv
// One interrupt source: edge detector plus its pending bit.
module int_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic mode,        // 1 = edge, 0 = level
  input  logic w1c,
  input  logic mode_change,
  output logic pend
);
  logic prev_q, prev_d;
  logic pend_q, pend_d;
  logic rise;

  assign rise = irq & ~prev_q;

  always_comb begin
    prev_d = irq;
    // A mode flip discards whatever was latched under the old mode.
    if (mode_change)  pend_d = 1'b0;
    else if (mode)    pend_d = rise | (pend_q & ~w1c);
    else              pend_d = irq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller top: register window decode, CTRL/MASK, ID encoder
// and the registered HWInt request vector.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE = BASE_ADDR
) (
  input  logic            clk,
  input  logic            reset,
  int_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] irq_src,
  output logic [NSRC-1:0] HWInt
);
  ctrl_t     ctrl_q, ctrl_d;
  src_vec_t  mask_q, mask_d;
  src_vec_t  hwint_q, hwint_d;
  src_vec_t  pend, masked, w1c, mode_chg;
  logic [1:0]  off;
  logic        wr;
  logic [31:0] rd, id;

  assign bus.hit = (bus.PrAddr[31:4] == BASE[31:4]);
  assign off     = bus.PrAddr[3:2];
  assign wr      = bus.hit & bus.PrWE;

  always_comb begin
    ctrl_d   = ctrl_q;
    mask_d   = mask_q;
    w1c      = '0;
    mode_chg = '0;
    if (wr) begin
      case (off)
        OFF_CTRL: begin
          ctrl_d.mode = bus.PrWD[NSRC-1:0];
          ctrl_d.gen  = bus.PrWD[CTRL_GEN_BIT];
          mode_chg    = bus.PrWD[NSRC-1:0] ^ ctrl_q.mode;
        end
        OFF_MASK: mask_d = bus.PrWD[NSRC-1:0];
        OFF_PEND: w1c    = bus.PrWD[NSRC-1:0];
        default:  ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      int_src_cell u_cell (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq_src[gi]),
        .mode        (ctrl_q.mode[gi]),
        .w1c         (w1c[gi]),
        .mode_change (mode_chg[gi]),
        .pend        (pend[gi])
      );
    end
  endgenerate

  assign masked  = pend & mask_q;
  assign hwint_d = masked & {NSRC{ctrl_q.gen}};

  always_comb begin
    id      = '0;
    id[31]  = (|masked) & ctrl_q.gen;
    id[2:0] = lowest_idx(masked);
  end

  always_comb begin
    rd = '0;
    case (off)
      OFF_CTRL: begin
        rd[NSRC-1:0]     = ctrl_q.mode;
        rd[CTRL_GEN_BIT] = ctrl_q.gen;
      end
      OFF_MASK: rd[NSRC-1:0] = mask_q;
      OFF_PEND: rd[NSRC-1:0] = pend;
      default:  rd = id;
    endcase
    bus.PrRD = bus.hit ? rd : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      mask_q  <= '0;
      hwint_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      mask_q  <= mask_d;
      hwint_q <= hwint_d;
    end
  end

  assign HWInt = hwint_q;
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Memory-mapped interrupt controller on the processor's peripheral bus (PrAddr/PrWD/PrWE/PrRD). It collects up to six device interrupt lines and conditions each one as level- or edge-sensitive, with per-source masking and a global enable. It drives the CPU's HWInt[7:2] input. Software configures and acknowledges sources through four word registers. No read has side effects, so a read issued by an instruction that is later flushed is harmless.

Parameters:
NSRC, 6, number of interrupt sources (maps to HWInt[7:2]; fixed at 6 for this CPU)
BASE_ADDR, 32'h00007f20, word-aligned base of the 16-byte register window

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
PrAddr  in  32  bus byte address from CPU M stage
PrWD  in  32  bus write data
PrWE  in  1  bus write enable (already gated by CPU with !IntReq)
PrRD  out  32  read data; combinational from registered state
hit  out  1  PrAddr falls inside [BASE_ADDR, BASE_ADDR+15]
irq_src  in  NSRC  raw device interrupt lines, synchronous to clk
HWInt  out  NSRC  registered interrupt requests to CPU (bit i -> HWInt[i+2])

Behaviour:
- Decode: hit = (PrAddr[31:4] == BASE_ADDR[31:4]). Offset is PrAddr[3:2]. PrAddr[1:0] is ignored. Writes take effect only when hit && PrWE, on the rising clk edge.
- Register map:
  - 0x0 CTRL: [5:0] MODE (1 = edge, 0 = level); [8] GEN (global enable). Other bits read 0.
  - 0x4 MASK: [5:0] per-source enable. Other bits read 0.
  - 0x8 PEND: [5:0] pending. Write-1-to-clear applies to edge sources only; for level sources the write is ignored.
  - 0xC ID: read-only. [31] = any (PEND & MASK) and GEN; [2:0] = lowest index set in PEND & MASK (0 when none). Writes are ignored.
- PrRD = register at offset when hit, else 32'h0.
- Reset: CTRL, MASK, PEND, the prev register and HWInt are all 0. PrRD follows 0-state decode.
- Edge detect: prev <= irq_src every cycle. rise = irq_src & ~prev.
- Pending update, per source i, each edge:
  - Edge mode: PEND[i] <= rise[i] | (PEND[i] & ~clr[i]), where clr = PrWD[5:0] on a PEND write. If a new rise coincides with a clear, the set wins.
  - Level mode: PEND[i] <= irq_src[i], so it tracks the line with one cycle of delay.
- A CTRL write that changes MODE[i] forces PEND[i] to 0 in that cycle; no stale edge survives a mode change.
- HWInt <= PEND & MASK & {NSRC{GEN}}, registered.
- Latency from irq_src rising at edge n:
  - PEND set at edge n+1.
  - HWInt asserted at edge n+2.
  - A W1C at edge k drops HWInt at edge k+1.
  - Clearing MASK or GEN at edge k drops HWInt at edge k+1.
- Edge sources: a line held high produces exactly one pending event. A further event requires the line to go low for at least one cycle, then high again.
- Reset asserted mid-operation clears all state on that edge, regardless of PrWE or irq_src.
- Writes to CTRL/MASK update only the defined bits; undefined bits are discarded.

Decomposition:
- Shared package int_ctrl_pkg:
  - offset constants OFF_CTRL=2'd0, OFF_MASK=2'd1, OFF_PEND=2'd2, OFF_ID=2'd3
  - CTRL_GEN_BIT=8
  - NSRC
  - default BASE_ADDR, reused by the system bridge decode
- Natural sub-module int_src_cell, instantiated NSRC times. It holds prev and PEND for one source, with inputs mode, w1c and mode_change, and outputs pend.
- The top level holds CTRL/MASK, the decode, the ID priority encoder and the HWInt register.

Test Plan:
1. Reset, then read 0x7f20/0x7f24/0x7f28/0x7f2c -> all 32'h0; HWInt = 6'b0; hit = 1 only for those addresses (0x7f1c and 0x7f30 give hit = 0, PrRD = 0).
2. Write CTRL = 32'h101 (GEN, src0 edge) and MASK = 32'h1; pulse irq_src[0] for 1 cycle at edge n -> PEND = 0x1 at n+1, HWInt = 6'b000001 at n+2, ID = 32'h80000000; write PEND = 32'h1 -> HWInt = 0 the next edge, ID[31] = 0.
3. Level source 3 with MASK[3] = 1 and GEN = 1: hold irq_src[3] high for 5 cycles -> HWInt[3] = 1 from 2 cycles after the rise until 2 cycles after the fall; a W1C write of 32'h8 mid-pulse has no effect.
4. Edge source 2: a rise coincides with a PEND W1C write of 32'h4 in the same cycle -> PEND[2] stays 1.
5. Sources 1 and 4 both pending and masked -> ID = 32'h80000001; clear MASK[1] -> ID = 32'h80000004; clear GEN -> HWInt = 0 next edge, PEND unchanged (reads 0x12).
6. Edge source 5 pending; write CTRL switching source 5 to level mode with irq_src[5] = 0 -> PEND[5] = 0 after the write edge. Separately, assert reset while PEND = 0x3F and a PrWE write is in flight -> all registers 0 and HWInt = 0 on that edge.
